core_id_stage: RTL

CORE_ID_STAGE -- requirements
Module: core_id_stage

---
 rtl/core_id_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/core_id_stage.sv
// Instruction decode stage: combinational RV32I field/immediate decode feeding
// a single pipeline register with reset, flush, stall and bubble control.
module core_id_stage #(
    parameter int CHECK_FUNCT7 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [31:0] o_immu,
    output logic [31:0] o_pc_immu,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic        o_rd_we,
    output logic        o_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        writes_rd;
    logic        illegal;
    logic        rd_we;
    logic        funct7_ok;

    assign opcode    = i_instr[6:0];
    assign funct3    = i_instr[14:12];
    assign funct7    = i_instr[31:25];
    assign rd        = i_instr[11:7];
    assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    always_comb begin
        imm       = 32'd0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            7'b0010011: begin
                imm       = {{20{i_instr[31]}}, i_instr[31:20]};
                writes_rd = 1'b1;
                // Shift immediates carry a funct7; only SRAI may use 0100000.
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = !funct7_ok;
            end
            7'b0000011, 7'b1100111: begin
                imm       = {{20{i_instr[31]}}, i_instr[31:20]};
                writes_rd = 1'b1;
            end
            7'b0100011: imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            7'b1100011: imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111: begin
                imm       = {i_instr[31:12], 12'd0};
                writes_rd = 1'b1;
            end
            7'b1101111: begin
                imm       = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            7'b0110011: begin
                writes_rd = 1'b1;
                illegal   = (CHECK_FUNCT7 != 0) && !funct7_ok;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rd_we = writes_rd && (rd != 5'd0) && !illegal;

    // Reset and flush both clear; a stall holds; otherwise load or bubble.
    always_ff @(posedge clk) begin
        if (rst || i_flush || (!i_stall && !i_valid)) begin
            o_valid    <= 1'b0;
            o_pc       <= 32'd0;
            o_opcode   <= 7'd0;
            o_funct3   <= 3'd0;
            o_funct7   <= 7'd0;
            o_immu     <= 32'd0;
            o_pc_immu  <= 32'd0;
            o_rs1_addr <= 5'd0;
            o_rs2_addr <= 5'd0;
            o_rd_addr  <= 5'd0;
            o_rd_we    <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (!i_stall) begin
            o_valid    <= 1'b1;
            o_pc       <= i_pc;
            o_opcode   <= opcode;
            o_funct3   <= funct3;
            o_funct7   <= funct7;
            o_immu     <= imm;
            o_pc_immu  <= i_pc + imm;
            o_rs1_addr <= i_instr[19:15];
            o_rs2_addr <= i_instr[24:20];
            o_rd_addr  <= rd;
            o_rd_we    <= rd_we;
            o_illegal  <= illegal;
        end
    end

endmodule
